scale_window: RTL and testbench
===============================

SCALE_WINDOW -- requirements
Module: scale_window

Interface
REQ-001 SHALL have parameter PIX_W, default 16, pixel width in bits.
REQ-002 SHALL have parameter SRC_W, default 240, source frame width in pixels.
REQ-003 SHALL have parameter SRC_H, default 320, source frame height in lines.
REQ-004 SHALL have parameter SCALE_W, default 2, scale selector width; factor = scale_in+1 (1..2^SCALE_W).
REQ-005 SHALL have parameter RD_LAT, default 2, frame-buffer read latency in cycles (>=1).
REQ-006 SHALL have localparam ADDR_W = $clog2(SRC_W*SRC_H).
REQ-007 Ports (one clock; reset asynchronous, active-low):
 clk_in  in  1  pixel clock
 rst_n_in  in  1  async active-low reset
 scale_in  in  SCALE_W  requested scale mode
 hcount_in  in  11  display column, +1 per cycle within a line
 vcount_in  in  10  display line
 hsync_in, vsync_in, blank_in  in  1 each  display timing
 fb_addr_out  out  ADDR_W  frame-buffer read address
 fb_data_in  in  PIX_W  frame-buffer read data, RD_LAT cycles after address
 cam_out  out  PIX_W  scaled pixel, 0 outside window
 hsync_out, vsync_out, blank_out  out  1 each  timing delayed to match cam_out

Function
REQ-008 SHALL latch scale_in into scale_q only on a cycle with hcount_in==0 and vcount_in==0; mid-frame scale_in changes SHALL NOT affect the current frame.
REQ-009 SHALL derive factor F = scale_q+1; no divider/multiplier on the pixel path.
REQ-010 Horizontal: hcount_in==0 -> src_x=0, sub_x=0; else sub_x==F-1 -> sub_x=0, src_x+1; else sub_x+1.
REQ-011 Vertical, evaluated on hcount_in==0 only: vcount_in==0 -> src_y=0, sub_y=0, row_base=0; else sub_y==F-1 -> sub_y=0, src_y+1, row_base+SRC_W; else sub_y+1.
REQ-012 src_x SHALL saturate at SRC_W and src_y at SRC_H; no wrap-around.
REQ-013 in_win = (src_x<SRC_W)&&(src_y<SRC_H), using the counter values for the current hcount/vcount.
REQ-014 fb_addr_out SHALL be registered: row_base+src_x when in_win, else holds last value; hcount at cycle N -> address at N+1.
REQ-015 in_win and hsync/vsync/blank SHALL pass through a (RD_LAT+1)-stage delay line aligned with fb_data_in.
REQ-016 cam_out SHALL be registered: delayed in_win ? fb_data_in : 0; total latency hcount_in -> cam_out = RD_LAT+2 cycles.
REQ-017 hsync_out/vsync_out/blank_out SHALL be delayed RD_LAT+2 cycles, cycle-aligned with cam_out.
REQ-018 Window for F=1: 240x320; F=2: 480x640; F=3: 720x960, clipped by the display raster.

Reset
REQ-019 On rst_n_in low, asynchronously: scale_q=0, all counters, row_base, fb_addr_out=0, cam_out=0, all delay stages=0, sync/blank outputs=0.
REQ-020 Reset mid-frame SHALL discard state; output resumes correctly from the next hcount_in==0&&vcount_in==0.

Structure
REQ-021 Shared package scale_pkg SHALL hold SRC_W/SRC_H defaults and the function returning factor from scale mode.
REQ-022 Delay line SHALL be sub-module delay_pipe (parameters WIDTH, DEPTH; async active-low reset), used for window flag and timing signals.

Verification
REQ-023 scale_in=0, raster sweep -> hcount 0..239, vcount 0..319 give fb_addr_out = vcount*240+hcount; cam_out=fb model data; hcount 240 -> cam_out=0.
REQ-024 scale_in=1 -> hcount 0,1 both address 0, 2 -> 1; vcount 2 line base 240; cam_out 0 at hcount>=480 or vcount>=640.
REQ-025 scale_in 0->1 at vcount=100 -> frame unchanged until next (0,0), then 2x mapping.
REQ-026 RD_LAT=3 -> cam_out and hsync_out both lag inputs exactly 5 cycles.
REQ-027 rst_n_in low at hcount=50, vcount=50 -> all outputs 0 asynchronously; correct frame after next (0,0).
REQ-028 scale_in=3 over 1280x1024 raster -> src_x saturates at 240, no address > 76799.

Source files
------------

// File: rtl/scale_pkg.sv
// Shared defaults and helpers for the scaled camera window.
// Holds source frame geometry and the scale-mode to factor mapping.
package scale_pkg;

  localparam int SRC_W_DEF = 240;
  localparam int SRC_H_DEF = 320;

  // Mode m replicates each source pixel (m+1) times in x and y.
  function automatic int unsigned scale_factor(input int unsigned mode);
    return mode + 1;
  endfunction

endpackage

// File: rtl/delay_pipe.sv
// Fixed-depth shift register with async active-low reset.
// Ports: clk_i, rst_n_i, d_i[WIDTH] in; q_o[WIDTH] = d_i delayed DEPTH cycles.
module delay_pipe #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/scale_window.sv
// Integer upscaler: maps display raster onto a stored frame by replication.
// Ports: raster/timing in, fb_addr_out/fb_data_in frame-buffer read, cam_out + timing out.
module scale_window
  import scale_pkg::*;
#(
  parameter int PIX_W   = 16,
  parameter int SRC_W   = SRC_W_DEF,
  parameter int SRC_H   = SRC_H_DEF,
  parameter int SCALE_W = 2,
  parameter int RD_LAT  = 2,
  localparam int ADDR_W = $clog2(SRC_W*SRC_H)
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic [SCALE_W-1:0] scale_in,
  input  logic [10:0]        hcount_in,
  input  logic [9:0]         vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               blank_in,
  output logic [ADDR_W-1:0]  fb_addr_out,
  input  logic [PIX_W-1:0]   fb_data_in,
  output logic [PIX_W-1:0]   cam_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               blank_out
);

  localparam int XW = $clog2(SRC_W+1);
  localparam int YW = $clog2(SRC_H+1);

  logic [SCALE_W-1:0] scale_q, scale_d;
  logic [SCALE_W-1:0] last_sub;
  logic [SCALE_W-1:0] sub_x_q, sub_x_d;
  logic [SCALE_W-1:0] sub_y_q, sub_y_d;
  logic [XW-1:0]      src_x_q, src_x_d;
  logic [YW-1:0]      src_y_q, src_y_d;
  logic [ADDR_W-1:0]  row_q, row_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PIX_W-1:0]   cam_q, cam_d;
  logic               hs_q, vs_q, bl_q;
  logic               line_start, frame_start;
  logic               in_win;
  logic [3:0]         dly;

  assign line_start  = (hcount_in == '0);
  assign frame_start = line_start && (vcount_in == '0);

  // Scale is sampled once per frame so a frame never mixes factors.
  assign scale_d  = frame_start ? scale_in : scale_q;
  assign last_sub = SCALE_W'(scale_factor(32'(scale_q)) - 1);

  // Counters hold the mapping of the previous pixel; the _d values
  // are the mapping of the pixel currently on hcount_in/vcount_in.
  always_comb begin
    sub_x_d = sub_x_q;
    src_x_d = src_x_q;
    if (line_start) begin
      sub_x_d = '0;
      src_x_d = '0;
    end else if (sub_x_q == last_sub) begin
      sub_x_d = '0;
      if (src_x_q != XW'(SRC_W)) src_x_d = src_x_q + 1'b1;
    end else begin
      sub_x_d = sub_x_q + 1'b1;
    end
  end

  always_comb begin
    sub_y_d = sub_y_q;
    src_y_d = src_y_q;
    row_d   = row_q;
    if (frame_start) begin
      sub_y_d = '0;
      src_y_d = '0;
      row_d   = '0;
    end else if (line_start) begin
      if (sub_y_q == last_sub) begin
        sub_y_d = '0;
        if (src_y_q != YW'(SRC_H)) begin
          src_y_d = src_y_q + 1'b1;
          row_d   = row_q + ADDR_W'(SRC_W);
        end
      end else begin
        sub_y_d = sub_y_q + 1'b1;
      end
    end
  end

  assign in_win = (src_x_d < XW'(SRC_W)) && (src_y_d < YW'(SRC_H));
  assign addr_d = in_win ? row_d + ADDR_W'(src_x_d) : addr_q;

  // Window flag and timing ride along with the read so they meet
  // fb_data_in on the same cycle.
  delay_pipe #(
    .WIDTH(4),
    .DEPTH(RD_LAT+1)
  ) u_dly (
    .clk_i  (clk_in),
    .rst_n_i(rst_n_in),
    .d_i    ({in_win, hsync_in, vsync_in, blank_in}),
    .q_o    (dly)
  );

  assign cam_d = dly[3] ? fb_data_in : '0;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      scale_q <= '0;
      sub_x_q <= '0;
      sub_y_q <= '0;
      src_x_q <= '0;
      src_y_q <= '0;
      row_q   <= '0;
      addr_q  <= '0;
      cam_q   <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      bl_q    <= 1'b0;
    end else begin
      scale_q <= scale_d;
      sub_x_q <= sub_x_d;
      sub_y_q <= sub_y_d;
      src_x_q <= src_x_d;
      src_y_q <= src_y_d;
      row_q   <= row_d;
      addr_q  <= addr_d;
      cam_q   <= cam_d;
      hs_q    <= dly[2];
      vs_q    <= dly[1];
      bl_q    <= dly[0];
    end
  end

  assign fb_addr_out = addr_q;
  assign cam_out     = cam_q;
  assign hsync_out   = hs_q;
  assign vsync_out   = vs_q;
  assign blank_out   = bl_q;

endmodule

// File: tb/tb_scale_window.sv
// Scoreboard bench for scale_window with a frame-level reference model.
// Random rasters, scales, timing bits; reset mid-frame; RD_LAT = 3.
module tb_scale_window;

  localparam int PIX_W   = 16;
  localparam int SRC_W   = 240;
  localparam int SRC_H   = 320;
  localparam int SCALE_W = 2;
  localparam int RD_LAT  = 3;
  localparam int LAT     = RD_LAT + 2;
  localparam int ADDR_W  = $clog2(SRC_W*SRC_H);
  localparam int NPIX    = SRC_W * SRC_H;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [SCALE_W-1:0] scale = '0;
  logic [10:0]        hcount = '0;
  logic [9:0]         vcount = '0;
  logic               hs = 1'b0, vs = 1'b0, bl = 1'b0;
  logic [ADDR_W-1:0]  fb_addr;
  logic [PIX_W-1:0]   fb_data;
  logic [PIX_W-1:0]   cam;
  logic               hs_o, vs_o, bl_o;

  scale_window #(
    .PIX_W  (PIX_W),
    .SRC_W  (SRC_W),
    .SRC_H  (SRC_H),
    .SCALE_W(SCALE_W),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk_in     (clk),
    .rst_n_in   (rst_n),
    .scale_in   (scale),
    .hcount_in  (hcount),
    .vcount_in  (vcount),
    .hsync_in   (hs),
    .vsync_in   (vs),
    .blank_in   (bl),
    .fb_addr_out(fb_addr),
    .fb_data_in (fb_data),
    .cam_out    (cam),
    .hsync_out  (hs_o),
    .vsync_out  (vs_o),
    .blank_out  (bl_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PIX_W-1:0] pix(input int a);
    int t;
    t = a * 40503 + 12345;
    return PIX_W'(t ^ (t >>> 7));
  endfunction

  // Frame buffer: returns data for an address RD_LAT cycles later.
  logic [ADDR_W-1:0] apipe [RD_LAT];
  initial for (int i = 0; i < RD_LAT; i++) apipe[i] = '0;
  always @(posedge clk) begin
    apipe[0] <= fb_addr;
    for (int i = 1; i < RD_LAT; i++) apipe[i] <= apipe[i-1];
  end
  assign fb_data = pix(int'(apipe[RD_LAT-1]));

  typedef struct {
    int             due;
    logic [PIX_W-1:0] cam;
    logic [2:0]     tim;
  } out_t;
  typedef struct {
    int due;
    int addr;
  } adr_t;

  out_t oq[$];
  adr_t aq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   push_en = 0;
  int   frame_f = 1;
  int   last_addr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
    end
  endtask

  // One raster cycle; the model maps the pixel straight from (h,v,F).
  task automatic pix_cycle(input int h, input int v, input int sc);
    int sx, sy;
    bit inw;
    @(posedge clk);
    #1;
    hcount = 11'(h);
    vcount = 10'(v);
    scale  = SCALE_W'(sc);
    hs = 1'($urandom);
    vs = 1'($urandom);
    bl = 1'($urandom);
    if (h == 0 && v == 0) begin
      push_en = 1;
      frame_f = sc + 1;
    end
    if (push_en) begin
      sx  = h / frame_f;
      sy  = v / frame_f;
      inw = (sx < SRC_W) && (sy < SRC_H);
      if (inw) last_addr = sy * SRC_W + sx;
      aq.push_back('{cyc + 1, last_addr});
      oq.push_back('{cyc + LAT, inw ? pix(last_addr) : '0, {hs, vs, bl}});
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_cam", int'(cam), 0);
    chk("rst_async_addr", int'(fb_addr), 0);
    chk("rst_async_tim", int'({hs_o, vs_o, bl_o}), 0);
    push_en = 0;
    oq.delete();
    aq.delete();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  // mode 0: scale_in steady; 1: random mid-frame; 2: switch from line 100.
  task automatic run_frame(input int fs, input int nl, input int wide,
                           input int step, input int mode, input int rl);
    for (int v = 0; v < nl; v++) begin
      int len;
      bit w;
      w = (v < 3) || (v % step == 0) || (v == nl - 1) || (v == rl) ||
          (v == SRC_H * (fs + 1) - 1) || (v == SRC_H * (fs + 1));
      len = w ? wide : int'($urandom_range(1, 6));
      for (int h = 0; h < len; h++) begin
        int sc;
        if (h == 0 && v == 0) sc = fs;
        else if (mode == 1) sc = int'($urandom_range(0, 3));
        else if (mode == 2 && v >= 100) sc = (fs + 1) % 4;
        else sc = fs;
        pix_cycle(h, v, sc);
        if (v == rl && h == 50) do_reset();
      end
    end
  endtask

  adr_t ea;
  out_t eo;
  always @(negedge clk) begin
    if (rst_n) begin
      if (push_en) begin
        n_tests++;
        if (int'(fb_addr) >= NPIX) begin
          n_fail++;
          $display("FAIL addr_range cyc=%0d got=%0d max=%0d",
                   cyc, fb_addr, NPIX - 1);
        end
      end
      if (aq.size() > 0 && aq[0].due <= cyc) begin
        ea = aq.pop_front();
        n_tests++;
        if (ea.due != cyc || int'(fb_addr) != ea.addr) begin
          n_fail++;
          $display("FAIL addr cyc=%0d due=%0d got=%0d exp=%0d",
                   cyc, ea.due, fb_addr, ea.addr);
        end
      end
      if (oq.size() > 0 && oq[0].due <= cyc) begin
        eo = oq.pop_front();
        n_tests++;
        if (eo.due != cyc || cam != eo.cam ||
            {hs_o, vs_o, bl_o} != eo.tim) begin
          n_fail++;
          $display("FAIL cam cyc=%0d due=%0d got=%h/%b exp=%h/%b",
                   cyc, eo.due, cam, {hs_o, vs_o, bl_o}, eo.cam, eo.tim);
        end
      end
    end
  end

  initial begin
    #500_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    chk("reset_cam", int'(cam), 0);
    chk("reset_addr", int'(fb_addr), 0);
    chk("reset_tim", int'({hs_o, vs_o, bl_o}), 0);
    #11 rst_n = 1'b1;

    run_frame(0, 330, 250, 61, 0, -1);
    run_frame(1, 650, 490, 97, 1, -1);
    run_frame(0, 330, 250, 61, 2, -1);
    run_frame(1, 330, 490, 97, 0, -1);
    run_frame(3, 1024, 1280, 500, 1, -1);
    run_frame(2, 60, 730, 300, 0, 50);
    run_frame(2, 970, 730, 300, 0, -1);
    for (int k = 0; k < 4; k++)
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(20, 150)),
                int'($urandom_range(250, 1000)), 40, 1, -1);

    repeat (LAT + 3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("queue_drain", oq.size() + aq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
